// File: rtl/store_buffer_drain.sv
// Drain engine that retires the oldest store buffer entry into the dcache data array.
// Optional saturating drain/stall counters are enabled with DCACHE_ST_DRAIN_STATS_EN.

package store_buffer_drain_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  way;
      logic [1:0]  thread_id;
      logic [63:0] data;
      logic [2:0]  size;
   } store_buffer_t;
endpackage

module store_buffer_drain
   import store_buffer_drain_pkg::*;
#(
   parameter int IDLE_DRAIN_CYCLES = 4,
   parameter int IDLE_CNT_WIDTH    = 8
)(
   input  logic          clock,
   input  logic          reset,
   input  logic          sb_empty,
   input  logic          sb_full,
   output logic          get_oldest,
   input  store_buffer_t oldest_info,
   input  logic          dcache_busy,
   input  logic          flush_req,
   output logic          flush_done,
   output logic          wr_valid,
   input  logic          wr_ready,
   output store_buffer_t wr_info,
   output logic          drain_busy
`ifdef DCACHE_ST_DRAIN_STATS_EN
   ,
   output logic [15:0]   stat_drained,
   output logic [15:0]   stat_stall
`endif
);

   typedef enum logic {IDLE, WRITE} state_t;

   localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_LIMIT = IDLE_CNT_WIDTH'(IDLE_DRAIN_CYCLES);

   state_t                    state_q, state_d;
   logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
   logic                      flush_pending_q, flush_pending_d;
   store_buffer_t             wr_info_q, wr_info_d;
   logic                      canDrain;
   logic                      drainCond;
   logic                      flushDone;

   // Pops are suppressed during reset so no entry is lost to a discarded register.
   assign canDrain  = !sb_empty && !dcache_busy && !reset;
   assign drainCond = canDrain &&
                      (sb_full || flush_pending_q || flush_req || (idle_cnt_q == IDLE_LIMIT));
   assign flushDone = flush_pending_q && sb_empty && (state_q == IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         idle_cnt_q      <= '0;
         flush_pending_q <= 1'b0;
         wr_info_q       <= '0;
      end else begin
         state_q         <= state_d;
         idle_cnt_q      <= idle_cnt_d;
         flush_pending_q <= flush_pending_d;
         wr_info_q       <= wr_info_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wr_info_d  = wr_info_q;
      unique case (state_q)
         IDLE: begin
            if (drainCond) begin
               state_d    = WRITE;
               wr_info_d  = oldest_info;
               idle_cnt_d = '0;
            end else if (canDrain) begin
               if (idle_cnt_q != IDLE_LIMIT) begin
                  idle_cnt_d = idle_cnt_q + IDLE_CNT_WIDTH'(1);
               end
            end else begin
               idle_cnt_d = '0;
            end
         end
         WRITE: begin
            idle_cnt_d = '0;
            if (wr_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A request landing on the completion cycle starts a fresh flush.
   always_comb begin
      flush_pending_d = flush_pending_q || flush_req;
      if (flushDone) begin
         flush_pending_d = flush_req;
      end
   end

   always_comb begin
      get_oldest = (state_q == IDLE) && drainCond;
      wr_valid   = (state_q == WRITE);
      drain_busy = (state_q != IDLE);
      flush_done = flushDone;
      wr_info    = wr_info_q;
   end

`ifdef DCACHE_ST_DRAIN_STATS_EN
   logic [15:0] stat_drained_q;
   logic [15:0] stat_stall_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_drained_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         if (wr_valid && wr_ready && (stat_drained_q != 16'hFFFF)) begin
            stat_drained_q <= stat_drained_q + 16'd1;
         end
         if (wr_valid && !wr_ready && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_q <= stat_stall_q + 16'd1;
         end
      end
   end

   assign stat_drained = stat_drained_q;
   assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_store_buffer_drain.sv
// Directed bench for store_buffer_drain with a small FIFO model standing in for the store buffer.

module tb_store_buffer_drain;
   import store_buffer_drain_pkg::*;

   logic          clock;
   logic          reset;
   logic          sb_empty;
   logic          sb_full;
   logic          get_oldest;
   store_buffer_t oldest_info;
   logic          dcache_busy;
   logic          flush_req;
   logic          flush_done;
   logic          wr_valid;
   logic          wr_ready;
   store_buffer_t wr_info;
   logic          drain_busy;
`ifdef DCACHE_ST_DRAIN_STATS_EN
   logic [15:0]   stat_drained;
   logic [15:0]   stat_stall;
`endif

   int nChecks = 0;
   int nFails  = 0;

   store_buffer_t sbMem [16];
   logic [3:0]    tail = 4'd0;
   logic [3:0]    head = 4'd0;
   logic [3:0]    sbCount;

   store_buffer_drain #(.IDLE_DRAIN_CYCLES(4), .IDLE_CNT_WIDTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .sb_empty    (sb_empty),
      .sb_full     (sb_full),
      .get_oldest  (get_oldest),
      .oldest_info (oldest_info),
      .dcache_busy (dcache_busy),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_info     (wr_info),
      .drain_busy  (drain_busy)
`ifdef DCACHE_ST_DRAIN_STATS_EN
      ,
      .stat_drained(stat_drained),
      .stat_stall  (stat_stall)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Four-entry store buffer model: the bench pushes, the DUT pops.
   assign sbCount     = tail - head;
   assign sb_empty    = (sbCount == 4'd0);
   assign sb_full     = (sbCount >= 4'd4);
   assign oldest_info = sb_empty ? '0 : sbMem[head];

   always @(posedge clock) begin
      if (get_oldest) begin
         head <= head + 4'd1;
      end
   end

   task automatic applyStimulus(input logic rst, input logic busy, input logic flush,
                                input logic ready, input int nPush, input logic [31:0] baseAddr);
      @(negedge clock);
      reset       = rst;
      dcache_busy = busy;
      flush_req   = flush;
      wr_ready    = ready;
      for (int i = 0; i < nPush; i++) begin
         sbMem[tail] = '{addr: baseAddr + 32'(i * 'h40), way: 2'd1, thread_id: 2'd2,
                         data: {32'hA5A5_0000, baseAddr + 32'(i * 'h40)}, size: 3'd3};
         tail = tail + 4'd1;
      end
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset       = 1'b1;
      dcache_busy = 1'b0;
      flush_req   = 1'b0;
      wr_ready    = 1'b0;

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("rst_wr_valid", wr_valid, 0);
      checkOutput("rst_get_oldest", get_oldest, 0);
      checkOutput("rst_drain_busy", drain_busy, 0);
      checkOutput("rst_flush_done", flush_done, 0);
      checkOutput("rst_wr_info", wr_info, 0);

      // Full trigger
      applyStimulus(0, 0, 0, 1, 4, 32'h0000_1040);
      checkOutput("full_pop", get_oldest, 1);
      checkOutput("full_pop_wr_valid", wr_valid, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("full_wr_valid", wr_valid, 1);
      checkOutput("full_wr_addr", wr_info.addr, 32'h0000_1040);
      checkOutput("full_wr_data", wr_info.data, 64'hA5A5_0000_0000_1040);
      checkOutput("full_no_pop_in_write", get_oldest, 0);
      checkOutput("full_drain_busy", drain_busy, 1);

      // Flush of the three remaining entries
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("flush_t_pop", get_oldest, 1);
      checkOutput("flush_t_wr_valid", wr_valid, 0);
      checkOutput("flush_t_done", flush_done, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t1_addr", wr_info.addr, 32'h0000_1080);
      checkOutput("flush_t1_pop", get_oldest, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t2_pop", get_oldest, 1);
      checkOutput("flush_t2_done", flush_done, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t3_addr", wr_info.addr, 32'h0000_10C0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t4_pop", get_oldest, 1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t5_wr_valid", wr_valid, 1);
      checkOutput("flush_t5_addr", wr_info.addr, 32'h0000_1100);
      checkOutput("flush_t5_done", flush_done, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t6_done", flush_done, 1);
      checkOutput("flush_t6_pop", get_oldest, 0);
      checkOutput("flush_t6_wr_valid", wr_valid, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("flush_t7_done", flush_done, 0);

      // Flush while already empty, then a re-arming request on the done cycle
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("eflush_req_cycle", flush_done, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("eflush_done", flush_done, 1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("eflush_rearm_done", flush_done, 1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("eflush_quiet", flush_done, 0);

      // Idle timeout with a single entry
      for (int c = 0; c <= 4; c++) begin
         applyStimulus(0, 0, 0, 1, (c == 0) ? 1 : 0, 32'h0000_2000);
         checkOutput($sformatf("idle_pop_c%0d", c), get_oldest, (c == 4) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("idle_wr_addr", wr_info.addr, 32'h0000_2000);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("idle_back_to_idle", wr_valid, 0);

      // Idle timeout restarted by a busy cycle
      for (int c = 0; c <= 7; c++) begin
         applyStimulus(0, (c == 2) ? 1 : 0, 0, 1, (c == 0) ? 1 : 0, 32'h0000_2040);
         checkOutput($sformatf("busyidle_pop_c%0d", c), get_oldest, (c == 7) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("busyidle_wr_addr", wr_info.addr, 32'h0000_2040);

      // Backpressure: three stall cycles then accept
      applyStimulus(0, 0, 0, 0, 4, 32'h0000_3000);
      checkOutput("bp_pop", get_oldest, 1);
      for (int s = 0; s < 3; s++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput($sformatf("bp_stall%0d_valid", s), wr_valid, 1);
         checkOutput($sformatf("bp_stall%0d_addr", s), wr_info.addr, 32'h0000_3000);
         checkOutput($sformatf("bp_stall%0d_pop", s), get_oldest, 0);
      end
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("bp_accept_valid", wr_valid, 1);
      checkOutput("bp_accept_addr", wr_info.addr, 32'h0000_3000);

      // Busy blocking with a full buffer
      for (int b = 0; b < 10; b++) begin
         applyStimulus(0, 1, 0, 1, (b == 0) ? 1 : 0, 32'h0000_3100);
         checkOutput($sformatf("busy_block%0d", b), get_oldest, 0);
         if (b == 0) begin
            checkOutput("busy_wr_valid", wr_valid, 0);
`ifdef DCACHE_ST_DRAIN_STATS_EN
            checkOutput("stat_drained", stat_drained, 16'd7);
            checkOutput("stat_stall", stat_stall, 16'd3);
`endif
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("busy_release_pop", get_oldest, 1);

      // Reset while stalled in WRITE with a captured flush request
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("rw_wr_valid", wr_valid, 1);
      checkOutput("rw_wr_addr", wr_info.addr, 32'h0000_3040);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("rw_hold_in_reset", wr_valid, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rw_wr_valid_dropped", wr_valid, 0);
      checkOutput("rw_drain_busy", drain_busy, 0);
      checkOutput("rw_flush_done", flush_done, 0);
      checkOutput("rw_no_pop", get_oldest, 0);
      checkOutput("rw_wr_info", wr_info, 0);
`ifdef DCACHE_ST_DRAIN_STATS_EN
      checkOutput("rw_stat_drained", stat_drained, 16'd0);
      checkOutput("rw_stat_stall", stat_stall, 16'd0);
`endif
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput($sformatf("rw_idle_pop_c%0d", c), get_oldest, (c == 4) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/store_buffer_drain.md
Name: store_buffer_drain

Overview:
- Drain engine on the consumer end of the dcache store buffer.
- Decides when to retire the oldest buffered store. Pops it via get_oldest/oldest_info, registers it, and presents it to the dcache data-array write port with a valid/ready handshake.
- Arbitrates drain against dcache load/fill activity.
- Supports an explicit flush, used for fences and thread switch.

Parameters:
- IDLE_DRAIN_CYCLES, 4: consecutive eligible idle cycles before an opportunistic drain. Legal range 1..255.
- IDLE_CNT_WIDTH, 8: width of the idle counter. Must hold IDLE_DRAIN_CYCLES.

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sb_empty  in  1  high when the store buffer holds no valid entry.
- sb_full  in  1  high when every store buffer entry is valid.
- get_oldest  out  1  pop strobe; the buffer invalidates its oldest entry at this clock edge.
- oldest_info  in  store_buffer_t  oldest entry, from registered buffer state, valid whenever sb_empty=0.
- dcache_busy  in  1  data array is owned this cycle by a load or line fill.
- flush_req  in  1  single-cycle drain-all request.
- flush_done  out  1  single-cycle pulse when a flush completes.
- wr_valid  out  1  store write request to the dcache data array.
- wr_ready  in  1  dcache accepts the write.
- wr_info  out  store_buffer_t  store being written (addr, way, thread_id, data, size).
- drain_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE, get_oldest=0, wr_valid=0, wr_info='0, flush_done=0, drain_busy=0, idle_cnt=0, flush_pending=0.
- Two-state FSM: IDLE, WRITE.
- Drain condition, evaluated in IDLE only: !sb_empty & !dcache_busy & (sb_full | flush_pending | flush_req | idle_cnt==IDLE_DRAIN_CYCLES).
- IDLE, condition true:
  - get_oldest=1 combinationally in that cycle.
  - oldest_info is registered into wr_info at that edge.
  - Next state is WRITE.
  - idle_cnt is cleared to 0.
- IDLE, condition false:
  - idle_cnt increments, saturating at IDLE_DRAIN_CYCLES, when !sb_empty & !dcache_busy.
  - Otherwise idle_cnt clears to 0.
- WRITE:
  - wr_valid=1; wr_info is held stable.
  - On wr_valid & wr_ready, the next state is IDLE.
  - Without wr_ready, hold state; wr_valid and wr_info do not change.
- Latency: pop edge to wr_valid high is 1 cycle. Minimum spacing between consecutive pops is 2 cycles (IDLE, WRITE).
- get_oldest is never asserted in WRITE and never asserted while sb_empty=1.
- dcache_busy blocks a new pop even when sb_full=1. It does not deassert wr_valid once in WRITE; wr_ready governs there.
- Flush:
  - flush_req sets the sticky flush_pending. A flush_req arriving in WRITE is also captured.
  - flush_done pulses for 1 cycle in the first cycle with flush_pending & sb_empty & state==IDLE. flush_pending clears at that edge.
  - flush_req while already empty and IDLE: flush_done is high on the next cycle.
  - A flush_req coincident with a flush_done cycle re-arms flush_pending.
- An entry removed from the buffer by an external search hit is simply not drained. The engine relies only on sb_empty/oldest_info in the pop cycle.
- Reset mid-WRITE: the registered entry is discarded, wr_valid drops the next cycle, and flush_pending is cleared.
- The wr_valid and get_oldest outputs must be glitch-free relative to clock; no combinational path from wr_ready to get_oldest.

Optional Feature:
- Macro: DCACHE_ST_DRAIN_STATS_EN.
- When defined, two extra outputs exist:
  - stat_drained, 16 bits: increments on each accepted write (wr_valid & wr_ready).
  - stat_stall, 16 bits: increments each cycle with wr_valid & !wr_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Full trigger: sb_full=1, sb_empty=0, dcache_busy=0, oldest_info.addr=32'h0000_1040 → get_oldest=1 the same cycle; next cycle wr_valid=1 with wr_info.addr=32'h0000_1040; wr_ready=1 → IDLE the following cycle.
- Idle timeout: IDLE_DRAIN_CYCLES=4, one entry present from cycle 0, dcache_busy=0, sb_full=0 → idle_cnt reads 0,1,2,3,4; get_oldest asserts in cycle 4 exactly; dcache_busy=1 at cycle 2 resets the count and delays the pop to cycle 7.
- Backpressure: wr_ready=0 for 3 cycles in WRITE → wr_valid held for 4 cycles, wr_info unchanged, get_oldest=0 throughout; with stats enabled, stat_stall=3 and stat_drained=1.
- Flush of 3 entries: flush_req pulse → 3 pops on cycles t, t+2, t+4 (wr_ready=1); sb_empty=1 after the third pop; flush_done pulses exactly once, in the first IDLE cycle after the last write is accepted.
- Busy blocking: sb_full=1, dcache_busy=1 for 10 cycles → get_oldest=0 for all 10; pop in the cycle dcache_busy falls.
- Reset in WRITE: reset asserted while wr_valid=1 & wr_ready=0 → next cycle wr_valid=0, drain_busy=0, flush_done=0, no get_oldest until a new drain condition arises.
